// File: rtl/cal_dac_pkg.sv
// Shared types and constants for the comparator threshold DAC driver.
package cal_dac_pkg;

  localparam int unsigned DAC_FRAME_BITS = 16;

  typedef enum logic [2:0] {
    IDLE,
    CS_SETUP,
    SHIFT,
    CS_HOLD,
    LDAC,
    SETTLE
  } dac_state_t;

endpackage

// File: rtl/spi_half_tick.sv
// SCLK half-period timer: one-cycle tick at the end of every CLK_DIV-cycle half-period.
module spi_half_tick #(
  parameter int unsigned CLK_DIV = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic restart_i,
  output logic tick_o
);

  localparam int unsigned CW = $clog2(CLK_DIV + 1);
  localparam logic [CW-1:0] RELOAD = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] ONE    = CW'(1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign tick_o = (cnt_q == '0);

  always_comb begin
    cnt_d = cnt_q - ONE;
    if (restart_i || (cnt_q == '0)) begin
      cnt_d = RELOAD;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/dac_threshold_drv.sv
// Threshold write responder: shifts a 16-bit code into a mode-0 SPI DAC, pulses LDAC,
// then waits for the analog level to settle before reporting ready again.
module dac_threshold_drv
  import cal_dac_pkg::*;
#(
  parameter int unsigned CLK_DIV       = 2,
  parameter int unsigned LDAC_CYCLES   = 2,
  parameter int unsigned SETTLE_CYCLES = 16
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [DAC_FRAME_BITS-1:0] threshold_i,
  input  logic                      threshold_wre_i,
  output logic                      threshold_rdy_o,
  output logic [DAC_FRAME_BITS-1:0] dac_value_o,
  output logic                      ovr_o,
  output logic                      dac_cs_n_o,
  output logic                      dac_sclk_o,
  output logic                      dac_din_o,
  output logic                      dac_ldac_n_o
);

  localparam int unsigned SMAX = (SETTLE_CYCLES > LDAC_CYCLES) ? SETTLE_CYCLES : LDAC_CYCLES;
  localparam int unsigned SW   = $clog2(SMAX + 1);
  localparam logic [SW-1:0] LDAC_LOAD   = SW'(LDAC_CYCLES - 1);
  localparam logic [SW-1:0] SETTLE_LOAD = SW'(SETTLE_CYCLES - 1);
  localparam logic [SW-1:0] SONE        = SW'(1);
  localparam logic [4:0]    LAST_BIT    = 5'(DAC_FRAME_BITS - 1);

  dac_state_t                state_q, state_d;
  logic [DAC_FRAME_BITS-1:0] shreg_q, shreg_d;
  logic [DAC_FRAME_BITS-1:0] code_q, code_d;
  logic [DAC_FRAME_BITS-1:0] dac_value_q, dac_value_d;
  logic [4:0]                bit_q, bit_d;
  logic [SW-1:0]             scnt_q, scnt_d;
  logic cs_n_q, cs_n_d, sclk_q, sclk_d, din_q, din_d, ldac_n_q, ldac_n_d, ovr_q, ovr_d;
  logic tick, restart;

  assign restart = (state_d != state_q);

  spi_half_tick #(.CLK_DIV(CLK_DIV)) u_half_tick (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .restart_i (restart),
    .tick_o    (tick)
  );

  // Pin outputs are decoded from the next state and registered, so pins never glitch.
  always_comb begin
    state_d     = state_q;
    shreg_d     = shreg_q;
    code_d      = code_q;
    dac_value_d = dac_value_q;
    bit_d       = bit_q;
    scnt_d      = scnt_q;
    cs_n_d      = cs_n_q;
    sclk_d      = sclk_q;
    din_d       = din_q;
    ldac_n_d    = ldac_n_q;
    ovr_d       = ovr_q | (threshold_wre_i && (state_q != IDLE));
    case (state_q)
      IDLE: begin
        if (threshold_wre_i) begin
          code_d  = threshold_i;
          shreg_d = threshold_i;
          din_d   = threshold_i[DAC_FRAME_BITS-1];
          cs_n_d  = 1'b0;
          sclk_d  = 1'b0;
          bit_d   = '0;
          state_d = CS_SETUP;
        end
      end
      CS_SETUP: begin
        if (tick) begin
          sclk_d  = 1'b1;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        // din advances on the falling edge; the bit index advances on the next rising edge.
        if (tick) begin
          if (sclk_q) begin
            sclk_d = 1'b0;
            if (bit_q != LAST_BIT) begin
              shreg_d = shreg_q << 1;
              din_d   = shreg_d[DAC_FRAME_BITS-1];
            end
          end else if (bit_q == LAST_BIT) begin
            state_d = CS_HOLD;
          end else begin
            bit_d  = bit_q + 5'd1;
            sclk_d = 1'b1;
          end
        end
      end
      CS_HOLD: begin
        if (tick) begin
          cs_n_d      = 1'b1;
          ldac_n_d    = 1'b0;
          dac_value_d = code_q;
          scnt_d      = LDAC_LOAD;
          state_d     = LDAC;
        end
      end
      LDAC: begin
        if (scnt_q == '0) begin
          ldac_n_d = 1'b1;
          scnt_d   = SETTLE_LOAD;
          state_d  = (SETTLE_CYCLES == 0) ? IDLE : SETTLE;
        end else begin
          scnt_d = scnt_q - SONE;
        end
      end
      SETTLE: begin
        if (scnt_q == '0) begin
          state_d = IDLE;
        end else begin
          scnt_d = scnt_q - SONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      shreg_q     <= '0;
      code_q      <= '0;
      dac_value_q <= '0;
      bit_q       <= '0;
      scnt_q      <= '0;
      cs_n_q      <= 1'b1;
      sclk_q      <= 1'b0;
      din_q       <= 1'b0;
      ldac_n_q    <= 1'b1;
      ovr_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      shreg_q     <= shreg_d;
      code_q      <= code_d;
      dac_value_q <= dac_value_d;
      bit_q       <= bit_d;
      scnt_q      <= scnt_d;
      cs_n_q      <= cs_n_d;
      sclk_q      <= sclk_d;
      din_q       <= din_d;
      ldac_n_q    <= ldac_n_d;
      ovr_q       <= ovr_d;
    end
  end

  assign threshold_rdy_o = (state_q == IDLE) & ~threshold_wre_i & ~rst_i;
  assign dac_value_o     = dac_value_q;
  assign ovr_o           = ovr_q;
  assign dac_cs_n_o      = cs_n_q;
  assign dac_sclk_o      = sclk_q;
  assign dac_din_o       = din_q;
  assign dac_ldac_n_o    = ldac_n_q;

endmodule

// File: tb/tb_dac_threshold_drv.sv
// Directed bench for dac_threshold_drv: default instance plus a fast-parameter instance.
module tb_dac_threshold_drv;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] thr;
  logic        wre_a, wre_b;

  logic        a_rdy, a_ovr, a_cs_n, a_sclk, a_din, a_ldac_n;
  logic [15:0] a_val;
  logic        b_rdy, b_ovr, b_cs_n, b_sclk, b_din, b_ldac_n;
  logic [15:0] b_val;

  int          checks = 0;
  int          errors = 0;
  int          rises, cs_lo, ldac_lo, rdy_cyc;
  logic [15:0] bits;

  always #5 clk = ~clk;

  dac_threshold_drv u_dut_a (
    .clk_i           (clk),
    .rst_i           (rst),
    .threshold_i     (thr),
    .threshold_wre_i (wre_a),
    .threshold_rdy_o (a_rdy),
    .dac_value_o     (a_val),
    .ovr_o           (a_ovr),
    .dac_cs_n_o      (a_cs_n),
    .dac_sclk_o      (a_sclk),
    .dac_din_o       (a_din),
    .dac_ldac_n_o    (a_ldac_n)
  );

  dac_threshold_drv #(
    .CLK_DIV       (1),
    .LDAC_CYCLES   (1),
    .SETTLE_CYCLES (0)
  ) u_dut_b (
    .clk_i           (clk),
    .rst_i           (rst),
    .threshold_i     (thr),
    .threshold_wre_i (wre_b),
    .threshold_rdy_o (b_rdy),
    .dac_value_o     (b_val),
    .ovr_o           (b_ovr),
    .dac_cs_n_o      (b_cs_n),
    .dac_sclk_o      (b_sclk),
    .dac_din_o       (b_din),
    .dac_ldac_n_o    (b_ldac_n)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Runs from cycle 1 until rdy rises (or limit), recording the SPI activity seen.
  task automatic run(input bit alt, input int limit, input int inj, input logic [15:0] inj_val);
    logic psclk, sclk, din, cs_n, ldac_n, rdy;
    psclk = 1'b0;
    rises = 0; cs_lo = 0; ldac_lo = 0; rdy_cyc = -1; bits = '0;
    for (int k = 1; k <= limit; k++) begin
      step();
      sclk   = alt ? b_sclk   : a_sclk;
      din    = alt ? b_din    : a_din;
      cs_n   = alt ? b_cs_n   : a_cs_n;
      ldac_n = alt ? b_ldac_n : a_ldac_n;
      rdy    = alt ? b_rdy    : a_rdy;
      if (!cs_n) cs_lo++;
      if (!ldac_n) ldac_lo++;
      if (sclk && !psclk) begin
        rises++;
        bits = {bits[14:0], din};
      end
      psclk = sclk;
      if (k == inj) thr = inj_val;
      if (alt) wre_b = (k == inj);
      else     wre_a = (k == inj);
      if (rdy) begin
        rdy_cyc = k;
        break;
      end
    end
  endtask

  initial begin
    rst = 1'b1; thr = '0; wre_a = 1'b0; wre_b = 1'b0;
    repeat (3) step();
    rst = 1'b0;
    #1;
    chk("rst_cs_n",   32'(a_cs_n),   32'd1);
    chk("rst_ldac_n", 32'(a_ldac_n), 32'd1);
    chk("rst_sclk",   32'(a_sclk),   32'd0);
    chk("rst_rdy",    32'(a_rdy),    32'd1);
    chk("rst_ovr",    32'(a_ovr),    32'd0);
    chk("rst_val",    32'(a_val),    32'd0);
    chk("rst_rdy_b",  32'(b_rdy),    32'd1);

    // Write A55A with default timing
    thr = 16'hA55A; wre_a = 1'b1;
    #1;
    chk("a55a_rdy_same_cycle", 32'(a_rdy), 32'd0);
    run(1'b0, 120, -1, 16'h0);
    chk("a55a_rises",   32'(rises),   32'd16);
    chk("a55a_bits",    32'(bits),    32'hA55A);
    chk("a55a_cs_lo",   32'(cs_lo),   32'd68);
    chk("a55a_ldac_lo", 32'(ldac_lo), 32'd2);
    chk("a55a_rdy_cyc", 32'(rdy_cyc), 32'd87);
    chk("a55a_val",     32'(a_val),   32'hA55A);
    chk("a55a_ovr",     32'(a_ovr),   32'd0);

    // Write while busy: second write dropped, ovr sticky
    thr = 16'h0001; wre_a = 1'b1;
    #1;
    run(1'b0, 120, 10, 16'hFFFF);
    chk("busy_bits",    32'(bits),    32'h0001);
    chk("busy_rises",   32'(rises),   32'd16);
    chk("busy_rdy_cyc", 32'(rdy_cyc), 32'd87);
    chk("busy_val",     32'(a_val),   32'h0001);
    chk("busy_ovr",     32'(a_ovr),   32'd1);

    // Reset mid-SHIFT
    thr = 16'h1234; wre_a = 1'b1;
    #1;
    step();
    wre_a = 1'b0;
    repeat (19) step();
    chk("midrst_cs_active", 32'(a_cs_n), 32'd0);
    rst = 1'b1;
    step();
    #1;
    chk("midrst_cs_n",    32'(a_cs_n),   32'd1);
    chk("midrst_sclk",    32'(a_sclk),   32'd0);
    chk("midrst_ldac_n",  32'(a_ldac_n), 32'd1);
    chk("midrst_val",     32'(a_val),    32'd0);
    chk("midrst_ovr",     32'(a_ovr),    32'd0);
    chk("midrst_rdy_rst", 32'(a_rdy),    32'd0);
    rst = 1'b0;
    #1;
    chk("midrst_rdy_rel", 32'(a_rdy), 32'd1);
    cs_lo = 0; ldac_lo = 0;
    for (int k = 0; k < 90; k++) begin
      step();
      if (!a_cs_n) cs_lo++;
      if (!a_ldac_n) ldac_lo++;
    end
    chk("midrst_no_cs",   32'(cs_lo),   32'd0);
    chk("midrst_no_ldac", 32'(ldac_lo), 32'd0);
    chk("midrst_val_end", 32'(a_val),   32'd0);

    // Fast parameter instance: CLK_DIV=1, LDAC_CYCLES=1, SETTLE_CYCLES=0
    thr = 16'h8000; wre_b = 1'b1;
    #1;
    chk("fast_rdy_same_cycle", 32'(b_rdy), 32'd0);
    run(1'b1, 60, -1, 16'h0);
    chk("fast_rises",   32'(rises),   32'd16);
    chk("fast_bits",    32'(bits),    32'h8000);
    chk("fast_cs_lo",   32'(cs_lo),   32'd34);
    chk("fast_ldac_lo", 32'(ldac_lo), 32'd1);
    chk("fast_rdy_cyc", 32'(rdy_cyc), 32'd36);
    chk("fast_val",     32'(b_val),   32'h8000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
